// File: rtl/cnn_frame_loader.sv
// cnn_frame_loader: streams one IMG_SIZE x IMG_SIZE image into a flat frame
// register for CNN_top, runs the CNN until done (with a timeout), and
// returns rho_out over a valid/ready result port.
module cnn_frame_loader #(
  parameter int unsigned IMG_SIZE    = 30,
  parameter int unsigned IMG_FLAT    = IMG_SIZE * IMG_SIZE,
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned TIMEOUT_CYC = 65535
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 s_valid,
  output logic                                 s_ready,
  input  logic signed [DATA_WIDTH-1:0]         s_data,
  input  logic                                 s_last,
  output logic        [DATA_WIDTH*IMG_FLAT-1:0] frame_out,
  output logic                                 cnn_enable,
  input  logic                                 cnn_done,
  input  logic signed [DATA_WIDTH-1:0]         cnn_rho,
  output logic                                 rho_valid,
  input  logic                                 rho_ready,
  output logic signed [DATA_WIDTH-1:0]         rho_data,
  output logic                                 err_len,
  output logic                                 err_timeout
);

  localparam int unsigned PTR_W = (IMG_FLAT > 1) ? $clog2(IMG_FLAT) : 1;
  localparam int unsigned CNT_W = (TIMEOUT_CYC == 0) ? 1 : $clog2(TIMEOUT_CYC + 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(IMG_FLAT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYC);
  localparam logic             TO_EN    = (TIMEOUT_CYC != 0);

  localparam logic [1:0] FILL    = 2'd0;
  localparam logic [1:0] DRAIN   = 2'd1;
  localparam logic [1:0] COMPUTE = 2'd2;
  localparam logic [1:0] HOLD    = 2'd3;

  logic [1:0]                   state_q, state_d;
  logic [PTR_W-1:0]             wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]             cnt_q, cnt_d;
  logic signed [DATA_WIDTH-1:0] rho_data_q, rho_data_d;
  logic                         s_ready_q, s_ready_d;
  logic                         cnn_enable_q, cnn_enable_d;
  logic                         rho_valid_q, rho_valid_d;
  logic                         err_len_q, err_len_d;
  logic                         err_to_q, err_to_d;
  logic                         buf_we_c;
  logic                         accept_c;
  logic [DATA_WIDTH-1:0]        buf_q [IMG_FLAT];

  assign accept_c = s_valid && s_ready_q;

  // Next-state, pointer, timeout counter and registered-output decode
  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    cnt_d        = cnt_q;
    rho_data_d   = rho_data_q;
    err_len_d    = 1'b0;
    err_to_d     = 1'b0;
    buf_we_c     = 1'b0;
    case (state_q)
      FILL: begin
        if (accept_c) begin
          buf_we_c = 1'b1;
          if (s_last) begin
            wr_ptr_d = '0;
            if (wr_ptr_q == PTR_LAST) begin
              state_d = COMPUTE;
              cnt_d   = '0;
            end else begin
              err_len_d = 1'b1;
            end
          end else if (wr_ptr_q == PTR_LAST) begin
            // Long frame: last slot is kept, the excess is drained
            err_len_d = 1'b1;
            wr_ptr_d  = '0;
            state_d   = DRAIN;
          end else begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
          end
        end
      end
      DRAIN: begin
        if (accept_c && s_last) begin
          state_d = FILL;
        end
      end
      COMPUTE: begin
        // done has priority over a simultaneous expiry
        if (cnn_done) begin
          rho_data_d = cnn_rho;
          state_d    = HOLD;
        end else if (TO_EN && (cnt_q == CNT_MAX)) begin
          err_to_d = 1'b1;
          state_d  = FILL;
        end else if (TO_EN) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      HOLD: begin
        if (rho_valid_q && rho_ready) begin
          state_d = FILL;
        end
      end
      default: begin
        state_d = FILL;
      end
    endcase
    s_ready_d    = (state_d == FILL) || (state_d == DRAIN);
    cnn_enable_d = (state_d == COMPUTE);
    rho_valid_d  = (state_d == HOLD);
  end

  // Control state and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= FILL;
      wr_ptr_q     <= '0;
      cnt_q        <= '0;
      rho_data_q   <= '0;
      s_ready_q    <= 1'b0;
      cnn_enable_q <= 1'b0;
      rho_valid_q  <= 1'b0;
      err_len_q    <= 1'b0;
      err_to_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      cnt_q        <= cnt_d;
      rho_data_q   <= rho_data_d;
      s_ready_q    <= s_ready_d;
      cnn_enable_q <= cnn_enable_d;
      rho_valid_q  <= rho_valid_d;
      err_len_q    <= err_len_d;
      err_to_q     <= err_to_d;
    end
  end

  // Frame buffer: written only by accepted samples in FILL
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < IMG_FLAT; i++) begin
        buf_q[i] <= '0;
      end
    end else if (buf_we_c) begin
      buf_q[wr_ptr_q] <= s_data;
    end
  end

  // Flatten buffer words onto the CNN data_in bus
  always_comb begin
    frame_out = '0;
    for (int i = 0; i < IMG_FLAT; i++) begin
      frame_out[i*DATA_WIDTH +: DATA_WIDTH] = buf_q[i];
    end
  end

  assign s_ready     = s_ready_q;
  assign cnn_enable  = cnn_enable_q;
  assign rho_valid   = rho_valid_q;
  assign rho_data    = rho_data_q;
  assign err_len     = err_len_q;
  assign err_timeout = err_to_q;

endmodule

// File: tb/tb_cnn_frame_loader.sv
// Directed self-checking bench for cnn_frame_loader (TIMEOUT_CYC = 20).
module tb_cnn_frame_loader;

  localparam int unsigned DW   = 16;
  localparam int unsigned FLAT = 900;
  localparam int unsigned TO   = 20;

  logic                    clk = 1'b0;
  logic                    reset = 1'b0;
  logic                    s_valid = 1'b0;
  logic                    s_ready;
  logic signed [DW-1:0]    s_data = '0;
  logic                    s_last = 1'b0;
  logic [DW*FLAT-1:0]      frame_out;
  logic                    cnn_enable;
  logic                    cnn_done = 1'b0;
  logic signed [DW-1:0]    cnn_rho = '0;
  logic                    rho_valid;
  logic                    rho_ready = 1'b0;
  logic signed [DW-1:0]    rho_data;
  logic                    err_len;
  logic                    err_timeout;

  int checks = 0;
  int errors = 0;
  int errlen_hits;
  int errlen_idx;

  cnn_frame_loader #(
    .IMG_SIZE(30), .IMG_FLAT(FLAT), .DATA_WIDTH(DW), .TIMEOUT_CYC(TO)
  ) dut (
    .clk(clk), .reset(reset),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .frame_out(frame_out), .cnn_enable(cnn_enable), .cnn_done(cnn_done),
    .cnn_rho(cnn_rho), .rho_valid(rho_valid), .rho_ready(rho_ready),
    .rho_data(rho_data), .err_len(err_len), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] gen(input int kind, input int i);
    case (kind)
      0:       return 16'(i);
      1:       return 16'(500 - i);
      2:       return 16'(3000 + i);
      3:       return 16'(7 * i);
      default: return 16'(i) ^ 16'hA5A5;
    endcase
  endfunction

  function automatic int frame_bad(input int kind);
    int n = 0;
    for (int i = 0; i < FLAT; i++) begin
      if (frame_out[i*DW +: DW] !== gen(kind, i)) n++;
    end
    return n;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Stream n samples of pattern 'kind'; optionally flag the last one
  task automatic send(input int n, input int kind, input bit with_last, input bit gaps);
    int w;
    errlen_hits = 0;
    errlen_idx  = -1;
    for (int i = 0; i < n; i++) begin
      if (gaps && ($urandom_range(0, 2) == 0)) begin
        s_valid = 1'b0;
        step();
      end
      s_valid = 1'b1;
      s_data  = gen(kind, i);
      s_last  = with_last && (i == n - 1);
      w = 0;
      while (!s_ready && w < 50) begin
        step();
        w++;
      end
      if (w >= 50) begin
        chk("accept_timeout", 32'(i), 32'(-1));
        break;
      end
      step();
      if (err_len) begin
        errlen_hits++;
        errlen_idx = i;
      end
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_s_ready"}, 32'(s_ready), 0);
    chk({tag, "_cnn_enable"}, 32'(cnn_enable), 0);
    chk({tag, "_rho_valid"}, 32'(rho_valid), 0);
    chk({tag, "_rho_data"}, 32'(rho_data), 0);
    chk({tag, "_err_len"}, 32'(err_len), 0);
    chk({tag, "_err_timeout"}, 32'(err_timeout), 0);
    chk({tag, "_frame_nonzero"}, 32'(|frame_out), 0);
  endtask

  initial begin
    int k;
    int bad;

    // Reset state
    repeat (3) step();
    chk_all_zero("rst");
    reset = 1'b1;
    step();
    chk("rst_release_s_ready", 32'(s_ready), 1);

    // Frame of value = index, then result -1234
    send(FLAT, 0, 1'b1, 1'b0);
    chk("f0_errlen", 32'(errlen_hits), 0);
    chk("f0_s_ready", 32'(s_ready), 0);
    chk("f0_cnn_enable", 32'(cnn_enable), 1);
    chk("f0_frame_bad", 32'(frame_bad(0)), 0);
    repeat (3) step();
    chk("f0_enable_held", 32'(cnn_enable), 1);
    chk("f0_rho_valid_early", 32'(rho_valid), 0);
    cnn_done = 1'b1;
    cnn_rho  = -16'sd1234;
    step();
    cnn_done = 1'b0;
    cnn_rho  = '0;
    chk("f0_rho_valid", 32'(rho_valid), 1);
    chk("f0_rho_data", 32'(rho_data), 32'(-1234));
    chk("f0_enable_off", 32'(cnn_enable), 0);

    // Backpressure on the result port
    for (int i = 0; i < 5; i++) begin
      step();
      chk("hold_rho_valid", 32'(rho_valid), 1);
      chk("hold_rho_data", 32'(rho_data), 32'(-1234));
      chk("hold_s_ready", 32'(s_ready), 0);
    end
    rho_ready = 1'b1;
    step();
    rho_ready = 1'b0;
    chk("hs_rho_valid", 32'(rho_valid), 0);
    chk("hs_s_ready", 32'(s_ready), 1);

    // cnn_done outside COMPUTE is ignored
    cnn_done = 1'b1;
    cnn_rho  = 16'sd77;
    step();
    cnn_done = 1'b0;
    chk("stray_done_rho_valid", 32'(rho_valid), 0);
    chk("stray_done_enable", 32'(cnn_enable), 0);
    chk("stray_done_s_ready", 32'(s_ready), 1);

    // Short frame: s_last on sample 10
    send(11, 3, 1'b1, 1'b0);
    chk("short_errlen_hits", 32'(errlen_hits), 1);
    chk("short_errlen_idx", 32'(errlen_idx), 10);
    chk("short_s_ready", 32'(s_ready), 1);
    chk("short_enable", 32'(cnn_enable), 0);

    // Valid frame afterwards with negative samples
    send(FLAT, 1, 1'b1, 1'b0);
    chk("f1_errlen", 32'(errlen_hits), 0);
    chk("f1_cnn_enable", 32'(cnn_enable), 1);
    chk("f1_frame_bad", 32'(frame_bad(1)), 0);
    cnn_done = 1'b1;
    cnn_rho  = 16'sh7FFF;
    step();
    cnn_done  = 1'b0;
    rho_ready = 1'b1;
    chk("f1_rho_data", 32'(rho_data), 32'h7FFF);
    step();
    rho_ready = 1'b0;
    chk("f1_hs_s_ready", 32'(s_ready), 1);

    // Long frame: 905 samples, s_last on the last
    send(905, 2, 1'b1, 1'b0);
    chk("long_errlen_hits", 32'(errlen_hits), 1);
    chk("long_errlen_idx", 32'(errlen_idx), 899);
    chk("long_s_ready", 32'(s_ready), 1);
    chk("long_enable", 32'(cnn_enable), 0);
    chk("long_frame_bad", 32'(frame_bad(2)), 0);

    // Timeout with cnn_done never asserted
    send(FLAT, 3, 1'b1, 1'b0);
    chk("to_enable", 32'(cnn_enable), 1);
    chk("to_frame_bad", 32'(frame_bad(3)), 0);
    k = 0;
    bad = 0;
    while (!err_timeout && k < 40) begin
      step();
      k++;
      if (!err_timeout && !cnn_enable) bad++;
    end
    chk("to_cycle", 32'(k), 21);
    chk("to_enable_early_drop", 32'(bad), 0);
    chk("to_enable_off", 32'(cnn_enable), 0);
    chk("to_s_ready", 32'(s_ready), 1);
    chk("to_rho_valid", 32'(rho_valid), 0);
    step();
    chk("to_pulse_width", 32'(err_timeout), 0);

    // cnn_done on the expiry cycle wins
    send(FLAT, 0, 1'b1, 1'b0);
    repeat (20) step();
    chk("exp_enable", 32'(cnn_enable), 1);
    chk("exp_no_early_to", 32'(err_timeout), 0);
    cnn_done = 1'b1;
    cnn_rho  = 16'sh1234;
    step();
    cnn_done = 1'b0;
    chk("exp_err_timeout", 32'(err_timeout), 0);
    chk("exp_rho_valid", 32'(rho_valid), 1);
    chk("exp_rho_data", 32'(rho_data), 32'h1234);
    step();
    chk("exp_no_late_to", 32'(err_timeout), 0);
    rho_ready = 1'b1;
    step();
    rho_ready = 1'b0;
    chk("exp_hs_s_ready", 32'(s_ready), 1);

    // Reset during COMPUTE
    send(FLAT, 4, 1'b1, 1'b0);
    repeat (3) step();
    chk("mid_compute_enable", 32'(cnn_enable), 1);
    reset = 1'b0;
    #1;
    chk_all_zero("rst_compute");
    step();
    reset = 1'b1;
    step();
    chk("rst_compute_release_s_ready", 32'(s_ready), 1);

    // Reset during FILL with gaps
    send(400, 4, 1'b0, 1'b1);
    chk("mid_fill_errlen", 32'(errlen_hits), 0);
    reset = 1'b0;
    #1;
    chk_all_zero("rst_fill");
    step();
    chk("rst_fill_held_s_ready", 32'(s_ready), 0);
    reset = 1'b1;
    step();
    chk("rst_fill_release_s_ready", 32'(s_ready), 1);

    // Full frame with gaps after reset
    send(FLAT, 4, 1'b1, 1'b1);
    chk("f4_errlen", 32'(errlen_hits), 0);
    chk("f4_cnn_enable", 32'(cnn_enable), 1);
    chk("f4_frame_bad", 32'(frame_bad(4)), 0);
    cnn_done = 1'b1;
    cnn_rho  = -16'sd1;
    step();
    cnn_done  = 1'b0;
    chk("f4_rho_valid", 32'(rho_valid), 1);
    chk("f4_rho_data", 32'(rho_data), 32'(-1));
    rho_ready = 1'b1;
    step();
    rho_ready = 1'b0;
    chk("f4_hs_rho_valid", 32'(rho_valid), 0);
    chk("f4_hs_s_ready", 32'(s_ready), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cnn_frame_loader.md
# cnn_frame_loader

Front-end feeder and result collector for `CNN_top`.
- Accepts one 30x30 spectrum image (one OSA trace) as a serial stream of signed samples and buffers it into a flat frame register that drives the CNN `data_in` array.
- Holds `enable` to the CNN until `done`, then captures `rho_out` and presents it on a valid/ready result port.
- Checks frame length and guards against a hung CNN with a timeout.

## Interface
- `IMG_SIZE`, 30: image side length.
- `IMG_FLAT`, `IMG_SIZE*IMG_SIZE`: samples per frame.
- `DATA_WIDTH`, 16: signed sample and result width.
- `TIMEOUT_CYC`, 65535: max cycles in COMPUTE waiting for `cnn_done`; 0 disables the timeout.
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `s_valid`  in  1  input sample valid.
- `s_ready`  out  1  loader accepts a sample; transfer when `s_valid && s_ready`.
- `s_data`  in  `DATA_WIDTH`  signed sample.
- `s_last`  in  1  marks the final sample of a frame.
- `frame_out`  out  `DATA_WIDTH*IMG_FLAT`  flat frame; word i is at bits `[i*DATA_WIDTH +: DATA_WIDTH]`; maps to CNN `data_in[i]`.
- `cnn_enable`  out  1  to CNN `enable`.
- `cnn_done`  in  1  from CNN `done`.
- `cnn_rho`  in  `DATA_WIDTH`  signed, from CNN `rho_out`.
- `rho_valid`  out  1  result valid.
- `rho_ready`  in  1  result consumer ready.
- `rho_data`  out  `DATA_WIDTH`  signed captured result.
- `err_len`  out  1  one-cycle pulse on a frame-length error.
- `err_timeout`  out  1  one-cycle pulse on a CNN timeout.

## Operation
- FSM states:
  - FILL: `s_ready`=1. An accepted sample writes buffer word `wr_ptr`, then `wr_ptr` increments.
    - `s_last`=1 at `wr_ptr==IMG_FLAT-1`: go to COMPUTE; clear `wr_ptr`.
    - `s_last`=1 at `wr_ptr<IMG_FLAT-1` (short frame): pulse `err_len`; clear `wr_ptr`; stay in FILL. Partial data stays in the buffer and is overwritten by the next frame.
    - `s_last`=0 at `wr_ptr==IMG_FLAT-1` (long frame): pulse `err_len`; clear `wr_ptr`; go to DRAIN. The sample at `IMG_FLAT-1` is still written.
  - DRAIN: `s_ready`=1. Accepted samples are discarded. The first accepted sample with `s_last`=1 returns the FSM to FILL.
  - COMPUTE: `cnn_enable`=1, `s_ready`=0, `frame_out` held stable. Timeout counter increments every cycle.
    - `cnn_done`=1: latch `cnn_rho` into `rho_data`; go to HOLD.
    - Counter reaches `TIMEOUT_CYC` with `TIMEOUT_CYC`≠0 and no `cnn_done`: pulse `err_timeout`; go to FILL; `rho_valid` stays 0.
    - `cnn_done` in the same cycle as expiry: `cnn_done` wins and no `err_timeout` pulse is produced.
  - HOLD: `rho_valid`=1, `cnn_enable`=0, `s_ready`=0. `rho_data` is stable until `rho_valid && rho_ready`, then the FSM goes to FILL.
- `cnn_done` outside COMPUTE is ignored.
- Timeout counter width is `$clog2(TIMEOUT_CYC+1)`. The counter clears on COMPUTE entry.
- The frame buffer is written only in FILL. Values pass through unmodified, with no scaling or saturation.

## Timing
- All outputs are registered.
- Reset values:
  - all outputs 0;
  - buffer and `frame_out` all 0;
  - FSM in FILL, `wr_ptr`=0.
- `s_ready` is 0 while `reset` is low and 1 in the first cycle after release.
- Final sample accepted at edge N:
  - `s_ready`=0 and `cnn_enable`=1 from N+1.
  - `frame_out` is complete at N+1.
- `cnn_done` sampled high at edge M:
  - `rho_valid`=1, `rho_data` valid, and `cnn_enable`=0 from M+1.
- Result handshake at edge K: `rho_valid`=0 and `s_ready`=1 from K+1.
- Timeout: `err_timeout` is high for one cycle, at the cycle after entering COMPUTE plus `TIMEOUT_CYC`. `cnn_enable`=0 and `s_ready`=1 in that same cycle.
- `err_len` is high the cycle after the offending sample is accepted.
- Asserting `reset` in any state immediately forces the reset values. The in-flight frame and any pending result are lost.
- Peak throughput is one sample per cycle. Minimum frame period is `IMG_FLAT` + CNN latency + 2 cycles.

## Test plan
- Stream 900 samples with value = index, `s_last` on sample 899 → `frame_out` word i = i. `cnn_enable` rises the cycle after the last sample. `cnn_done` with `cnn_rho`=-1234 → `rho_valid`=1 next cycle with `rho_data`=-1234.
- In HOLD, hold `rho_ready`=0 for 5 cycles → `rho_valid` and `rho_data` stay stable and `s_ready`=0. Then `rho_ready`=1 → `s_ready`=1 next cycle.
- Send a short frame (`s_last` on sample 10) → one `err_len` pulse, FSM stays in FILL. A following valid 900-sample frame processes normally.
- Send 905 samples with `s_last` on the last one → `err_len` pulse after sample 899, DRAIN until `s_last`, then back to FILL with buffer words 0..899 intact.
- `TIMEOUT_CYC`=20, `cnn_done` never asserted → `err_timeout` pulses 21 cycles after COMPUTE entry, `cnn_enable`=0, `s_ready`=1. Repeat with `cnn_done` exactly on the expiry cycle → result captured, no `err_timeout`.
- Assert `reset` mid-COMPUTE and mid-FILL (with random `s_valid` gaps) → all outputs 0 immediately. After release `s_ready`=1 and the next full frame processes correctly.
